// File: rtl/key_sched_ctrl_if.sv
// Key-load handshake and round-key read bus of key_sched_ctrl.
// The slave modport is the controller; the master modport is the key source / round core side.
interface key_sched_ctrl_if;
    logic         key_valid_i;
    logic         key_ready_o;
    logic [127:0] key_i;
    logic         rk_req_i;
    logic [3:0]   rk_idx_i;
    logic         rk_valid_o;
    logic [127:0] rk_o;
    logic         rk_err_o;

    modport slave (
        input  key_valid_i,
        input  key_i,
        input  rk_req_i,
        input  rk_idx_i,
        output key_ready_o,
        output rk_valid_o,
        output rk_o,
        output rk_err_o
    );

    modport master (
        output key_valid_i,
        output key_i,
        output rk_req_i,
        output rk_idx_i,
        input  key_ready_o,
        input  rk_valid_o,
        input  rk_o,
        input  rk_err_o
    );
endinterface

// File: rtl/key_sched_ctrl.sv
// Sequencer for key_expansion: launches one expansion per accepted key, banks the round keys,
// serves them by round index and flags expansion timeouts. Define KEY_CACHE_EN to skip re-expanding an unchanged key.
module key_sched_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int NUM_ROUNDS     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    key_sched_ctrl_if.slave      bus,
    output logic                 kexp_valid_o,
    output logic [127:0]         kexp_key_o,
    input  logic                 kexp_valid_i,
    input  logic [127:0]         kexp_round_key_i [NUM_ROUNDS:0],
    output logic                 keys_ready_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_READY,
        S_ERR
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_IDX     = 4'(NUM_ROUNDS);

    state_t         state_reg;
    logic [127:0]   key_reg;
    logic [7:0]     cnt_reg;
    logic           kexp_valid_reg;
    logic [127:0]   kexp_key_reg;
    logic           keys_ready_reg;
    logic           err_reg;
    logic           rk_valid_reg;
    logic [127:0]   rk_reg;
    logic           rk_err_reg;
    logic [127:0]   bank_q [NUM_ROUNDS+1];

    logic key_ready;
    logic key_accept;
    logic cache_hit;
    logic capture;
    logic rd_go;
    logic idx_ok;

    assign key_ready  = (state_reg == S_IDLE) || (state_reg == S_READY) || (state_reg == S_ERR);
    assign key_accept = bus.key_valid_i && key_ready;
    assign capture    = (state_reg == S_WAIT) && kexp_valid_i;
    assign rd_go      = (state_reg == S_READY) && bus.rk_req_i;
    assign idx_ok     = (bus.rk_idx_i <= LAST_IDX);

`ifdef KEY_CACHE_EN
    logic bank_valid_reg;
    // Only a READY bank built from the very same key can be reused.
    assign cache_hit = (state_reg == S_READY) && bank_valid_reg && (bus.key_i == key_reg);
`else
    assign cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            key_reg        <= '0;
            cnt_reg        <= '0;
            kexp_valid_reg <= 1'b0;
            kexp_key_reg   <= '0;
            keys_ready_reg <= 1'b0;
            err_reg        <= 1'b0;
`ifdef KEY_CACHE_EN
            bank_valid_reg <= 1'b0;
`endif
        end else begin
            kexp_valid_reg <= 1'b0;
            kexp_key_reg   <= '0;
            unique case (state_reg)
                S_IDLE, S_READY, S_ERR: begin
                    if (key_accept) begin
                        key_reg <= bus.key_i;
                        if (!cache_hit) begin
                            state_reg      <= S_LAUNCH;
                            kexp_valid_reg <= 1'b1;
                            kexp_key_reg   <= bus.key_i;
                            keys_ready_reg <= 1'b0;
                            err_reg        <= 1'b0;
`ifdef KEY_CACHE_EN
                            bank_valid_reg <= 1'b0;
`endif
                        end
                    end
                end
                S_LAUNCH: begin
                    state_reg <= S_WAIT;
                    cnt_reg   <= '0;
                end
                S_WAIT: begin
                    // A capture on the final counted cycle still beats the timeout.
                    if (kexp_valid_i) begin
                        state_reg      <= S_READY;
                        keys_ready_reg <= 1'b1;
`ifdef KEY_CACHE_EN
                        bank_valid_reg <= 1'b1;
`endif
                    end else if (cnt_reg == TIMEOUT_LAST) begin
                        state_reg <= S_ERR;
                        err_reg   <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi <= NUM_ROUNDS; gi++) begin : g_bank
            logic [127:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (capture) begin
                    entry_reg <= kexp_round_key_i[gi];
                end
            end
            assign bank_q[gi] = entry_reg;
        end
    endgenerate

    // Reads see the bank as it stood before this edge, so a read racing a new key gets the old bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_valid_reg <= 1'b0;
            rk_err_reg   <= 1'b0;
            rk_reg       <= '0;
        end else if (rd_go) begin
            rk_valid_reg <= 1'b1;
            rk_err_reg   <= !idx_ok;
            rk_reg       <= idx_ok ? bank_q[bus.rk_idx_i] : '0;
        end else begin
            rk_valid_reg <= 1'b0;
            rk_err_reg   <= 1'b0;
            rk_reg       <= '0;
        end
    end

    assign bus.key_ready_o = key_ready;
    assign bus.rk_valid_o  = rk_valid_reg;
    assign bus.rk_o        = rk_reg;
    assign bus.rk_err_o    = rk_err_reg;
    assign kexp_valid_o    = kexp_valid_reg;
    assign kexp_key_o      = kexp_key_reg;
    assign keys_ready_o    = keys_ready_reg;
    assign err_o           = err_reg;

endmodule

// File: doc/key_sched_ctrl.md
Name: key_sched_ctrl

Overview:
Sequencing controller for the key_expansion datapath. It accepts cipher keys over a valid/ready handshake and launches one key_expansion run per key. It captures the 11 round keys into a local bank and serves them one round at a time, by round index, to the AES round core. It also supervises the expansion with a timeout and reports status.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT for kexp_valid_i before declaring an error (range 2..255)
NUM_ROUNDS, 10, AES-128 round count; the bank holds NUM_ROUNDS+1 keys

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
key_valid_i  input  1  new cipher key offered
key_ready_o  output  1  controller can accept a key
key_i  input  128  cipher key
kexp_valid_o  output  1  to key_expansion valid_i
kexp_key_o  output  128  to key_expansion key_i
kexp_valid_i  input  1  from key_expansion valid_o
kexp_round_key_i  input  128 x 11  from key_expansion round_key_o[10:0]
rk_req_i  input  1  round-key read request
rk_idx_i  input  4  requested round index
rk_valid_o  output  1  rk_o valid (1 cycle after request)
rk_o  output  128  requested round key
rk_err_o  output  1  pulses with rk_valid_o when rk_idx_i > NUM_ROUNDS
keys_ready_o  output  1  bank holds a complete expansion of the last accepted key
err_o  output  1  expansion timeout; sticky until next key accepted

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - These outputs are 0: kexp_valid_o, rk_valid_o, rk_err_o, keys_ready_o, err_o, kexp_key_o, rk_o.
  - Bank cleared to 0; timeout counter = 0.
  - Reset asserted mid-WAIT aborts the run. A late kexp_valid_i after reset is ignored because state is IDLE.
- States:
  - IDLE → LAUNCH on key accept.
  - LAUNCH → WAIT unconditionally. LAUNCH lasts 1 cycle.
  - WAIT → READY on kexp_valid_i.
  - WAIT → ERR when the counter reaches TIMEOUT_CYCLES.
  - READY → LAUNCH on key accept.
  - ERR → LAUNCH on key accept.
- key_ready_o = 1 in IDLE, READY and ERR; 0 in LAUNCH and WAIT. The handshake completes when key_valid_i && key_ready_o on a rising edge; key_i is captured into the key register.
- On key accept: keys_ready_o and err_o clear on the next cycle.
- LAUNCH: kexp_valid_o=1 for exactly one cycle, with kexp_key_o = captured key. Otherwise kexp_valid_o=0 and kexp_key_o=0.
- WAIT:
  - The counter starts at 0 on WAIT entry and increments each cycle.
  - On kexp_valid_i, all 11 round keys latch into the bank on that edge. The next cycle has state READY and keys_ready_o=1.
  - kexp_valid_i arriving while not in WAIT is ignored and the bank is unchanged.
  - kexp_valid_i in the same cycle the counter hits TIMEOUT_CYCLES: the capture wins, go to READY, no error.
  - On timeout: state ERR, err_o=1, keys_ready_o=0.
- Reads:
  - A read is accepted only in READY with rk_req_i=1.
  - Next cycle: rk_valid_o=1 and rk_o=bank[rk_idx_i].
  - If rk_idx_i > NUM_ROUNDS: rk_o=0 and rk_err_o=1.
  - Back-to-back reads are allowed, one per cycle.
  - rk_req_i outside READY is dropped: rk_valid_o stays 0.
  - When rk_valid_o=0, rk_o=0.
- Simultaneous key accept and rk_req_i in READY: the read is served from the old bank. The bank is not overwritten until the new kexp_valid_i.

Optional Feature:
KEY_CACHE_EN
- Defined:
  - The controller keeps a "bank valid" flag alongside the stored key.
  - A key accepted in READY that equals the stored key skips expansion: state stays READY, keys_ready_o stays 1, kexp_valid_o is not pulsed.
  - In IDLE/ERR, or when the key differs, expansion launches as normal.
- Undefined: every accepted key launches an expansion.

Test Plan:
- Reset, then load key 2b7e151628aed2a6abf7158809cf4f3c; model responds 5 cycles after kexp_valid_o → exactly one kexp_valid_o pulse with that key; key_ready_o=0 during LAUNCH/WAIT; keys_ready_o=1 one cycle after kexp_valid_i.
- In READY, read idx 0, 1, 10 back-to-back → rk_o = 2b7e1516…4f3c, a0fafe1788542cb123a339392a6c7605, d014f9a8c9ee2589e13f0cc8b6630ca6, each one cycle after its request; idx 11 → rk_o=0, rk_err_o=1.
- Model never answers → err_o=1 after 64 WAIT cycles and keys_ready_o=0; a new key then recovers to READY.
- kexp_valid_i in the same cycle as the timeout → READY, err_o=0.
- Reload the same key in READY: with KEY_CACHE_EN, no kexp_valid_o and keys_ready_o stays 1; without it, one pulse and keys_ready_o drops for the run.
- Assert rst_n=0 mid-WAIT, release, then pulse a stray kexp_valid_i → state IDLE, all outputs 0, bank unchanged at 0.
